// File: rtl/result_tx_encoder.sv
// result_tx_encoder
//   Return path of the UART coprocessor link. Takes one coprocessor result word,
//   sends it as ASCII hex digits (most significant nibble first), then sends a
//   terminator byte. Bytes are handed to uart_tx one at a time through a
//   start/busy handshake.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   result_data   coprocessor result word
//   result_valid  1-cycle strobe qualifying result_data
//   tx_busy       uart_tx busy, high from the cycle after tx_start until byte done
//   tx_data       byte presented to uart_tx, held while a byte is in flight
//   tx_start      1-cycle pulse, uart_tx loads tx_data
//   encoder_busy  high from result capture until the terminator has completed
//   overrun       sticky, a result arrived while busy; cleared by the next accepted result
//
// DATA_WIDTH must be a multiple of 4.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for result_valid
// S_LOAD       | present ASCII of the top nibble on tx_data
// S_START      | pulse tx_start once uart_tx is free
// S_HOLD       | one cycle for uart_tx to raise busy; shift to next nibble
// S_WAIT       | wait for the digit to finish, then next digit or terminator
// S_TERM_START | pulse tx_start for the terminator once uart_tx is free
// S_TERM_HOLD  | one cycle for uart_tx to raise busy
// S_TERM_WAIT  | wait for the terminator to finish, then release encoder_busy

module result_tx_encoder #(
  parameter int         DATA_WIDTH = 16,
  parameter logic [7:0] TERMINATOR = 8'h0A,
  parameter bit         UPPERCASE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] result_data,
  input  logic                  result_valid,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic                  encoder_busy,
  output logic                  overrun
);

  localparam int NDIG = DATA_WIDTH / 4;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_HOLD,
    S_WAIT,
    S_TERM_START,
    S_TERM_HOLD,
    S_TERM_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else if (UPPERCASE)
      return 8'h37 + {4'h0, n};
    else
      return 8'h57 + {4'h0, n};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;

    // busy_q is still high during the last TERM_WAIT cycle, so a result
    // arriving on that cycle is dropped as well.
    if (result_valid && busy_q)
      overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (result_valid) begin
          shift_d   = result_data;
          cnt_d     = CW'(NDIG);
          busy_d    = 1'b1;
          overrun_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_data_d = hex_ascii(shift_q[DATA_WIDTH-1 -: 4]);
        state_d   = S_START;
      end
      S_START: begin
        if (!tx_busy)
          state_d = S_HOLD;
      end
      S_HOLD: begin
        // tx_busy is not yet valid here; uart_tx raises it one cycle after tx_start.
        shift_d = shift_q << 4;
        cnt_d   = cnt_q - 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!tx_busy) begin
          if (cnt_q != '0) begin
            state_d = S_LOAD;
          end else begin
            tx_data_d = TERMINATOR;
            state_d   = S_TERM_START;
          end
        end
      end
      S_TERM_START: begin
        if (!tx_busy)
          state_d = S_TERM_HOLD;
      end
      S_TERM_HOLD: begin
        state_d = S_TERM_WAIT;
      end
      S_TERM_WAIT: begin
        if (!tx_busy) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_start = 1'b0;
    if ((state_q == S_START || state_q == S_TERM_START) && !tx_busy)
      tx_start = 1'b1;
  end

  assign tx_data      = tx_data_q;
  assign encoder_busy = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_result_tx_encoder.sv
// tb_result_tx_encoder
//   Drives result words into result_tx_encoder against a simple uart_tx busy
//   model. A byte-level reference model predicts the transmitted byte stream,
//   encoder_busy and overrun; a compare process checks every cycle. Directed
//   scenarios pin literal byte sequences, then a randomized phase follows.
//   A second instance with lowercase digits checks the a-f mapping.

module tb_result_tx_encoder;

  localparam int NDIG = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] result_data;
  logic        result_valid;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        encoder_busy;
  logic        overrun;

  logic [15:0] result_data_lc;
  logic        result_valid_lc;
  logic        tx_busy_lc;
  logic [7:0]  tx_data_lc;
  logic        tx_start_lc;
  logic        encoder_busy_lc;
  logic        overrun_lc;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  result_tx_encoder #(.DATA_WIDTH(16), .TERMINATOR(8'h0A), .UPPERCASE(1'b1)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .result_data  (result_data),
    .result_valid (result_valid),
    .tx_busy      (tx_busy),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .encoder_busy (encoder_busy),
    .overrun      (overrun)
  );

  result_tx_encoder #(.DATA_WIDTH(16), .TERMINATOR(8'h0A), .UPPERCASE(1'b0)) u_dut_lc (
    .clk          (clk),
    .rst          (rst),
    .result_data  (result_data_lc),
    .result_valid (result_valid_lc),
    .tx_busy      (tx_busy_lc),
    .tx_data      (tx_data_lc),
    .tx_start     (tx_start_lc),
    .encoder_busy (encoder_busy_lc),
    .overrun      (overrun_lc)
  );

  // uart_tx models: busy for a number of cycles starting the cycle after tx_start
  int bcnt       = 0;
  int busy_len   = 10;
  bit busy_rand  = 1'b0;
  bit force_busy = 1'b0;
  int bcnt_lc    = 0;

  always @(posedge clk) begin
    if (tx_start)
      bcnt <= busy_rand ? int'($urandom_range(6, 1)) : busy_len;
    else if (bcnt != 0)
      bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0) || force_busy;

  always @(posedge clk) begin
    if (tx_start_lc)
      bcnt_lc <= 3;
    else if (bcnt_lc != 0)
      bcnt_lc <= bcnt_lc - 1;
  end
  assign tx_busy_lc = (bcnt_lc != 0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte queue of the frame still to send, busy and overrun flags.
  string      hexs = "0123456789ABCDEF";
  logic [7:0] exp_q[$];
  bit         m_busy = 1'b0;
  bit         m_ovr  = 1'b0;
  int         m_left = 0;
  int         m_term = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_ovr  <= 1'b0;
      m_left <= 0;
      exp_q.delete();
    end else begin
      // Busy ends at the first edge, two or more after the terminator launch,
      // at which the uart is free.
      if (m_busy && m_left == 0 && cyc >= m_term + 2 && !tx_busy)
        m_busy <= 1'b0;
      if (tx_start && m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1)
          m_term <= cyc;
        if (exp_q.size() != 0)
          void'(exp_q.pop_front());
      end
      if (result_valid) begin
        if (m_busy) begin
          m_ovr <= 1'b1;
        end else begin
          m_busy <= 1'b1;
          m_ovr  <= 1'b0;
          m_left <= NDIG + 1;
          for (int i = NDIG - 1; i >= 0; i--)
            exp_q.push_back(hexs[int'((result_data >> (4 * i)) & 16'hF)]);
          exp_q.push_back(8'h0A);
        end
      end
    end
  end

  // Per-cycle compare, sampled on the falling edge
  logic [7:0] log_q[$];
  int         log_c[$];
  logic [7:0] log_lc[$];
  logic [7:0] prev_data = 8'h00;
  int         prev_bcnt = 0;
  bit         prev_rst  = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", {21'b0, tx_data, tx_start, encoder_busy, overrun}, 32'h0);
    end else begin
      chk("encoder_busy", {31'b0, encoder_busy}, {31'b0, m_busy});
      chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
      if (tx_start) begin
        chk("start_while_uart_busy", {31'b0, tx_busy}, 32'h0);
        chk("start_with_byte_pending", {31'b0, exp_q.size() != 0}, 32'h1);
        if (exp_q.size() != 0)
          chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_q[0]});
        log_q.push_back(tx_data);
        log_c.push_back(cyc);
      end
      if (prev_rst && bcnt != 0 && prev_bcnt != 0)
        chk("tx_data_stable", {24'b0, tx_data}, {24'b0, prev_data});
    end
    prev_rst  <= rst;
    prev_bcnt <= bcnt;
    prev_data <= tx_data;
  end

  always @(negedge clk) begin
    if (tx_start_lc)
      log_lc.push_back(tx_data_lc);
  end

  task automatic send(input logic [15:0] d, output int c);
    @(posedge clk); #1;
    result_data  = d;
    result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
    c = cyc;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((encoder_busy || m_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_completes"}, {31'b0, n < 3000}, 32'h1);
  endtask

  task automatic chk_frame(input string nm, input int base, input int n_exp, input logic [39:0] bytes5);
    chk({nm, "_byte_count"}, log_q.size() - base, n_exp);
    for (int i = 0; i < 5; i++)
      if (base + i < log_q.size())
        chk({nm, "_byte"}, {24'b0, log_q[base + i]}, {24'b0, bytes5[39 - 8 * i -: 8]});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int base;
    int n;

    rst             = 1'b0;
    result_data     = 16'h0;
    result_valid    = 1'b0;
    result_data_lc  = 16'h0;
    result_valid_lc = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: 16'h1A2F, 10-cycle uart
    base = log_q.size();
    send(16'h1A2F, c);
    wait_idle("t1");
    chk_frame("t1", base, 5, 40'h31_41_32_46_0A);
    if (log_c.size() > base)
      chk("t1_first_start_latency", log_c[base], c + 1);

    // 2: all zeros; all ones on the lowercase instance
    base = log_q.size();
    send(16'h0000, c);
    wait_idle("t2");
    chk_frame("t2", base, 5, 40'h30_30_30_30_0A);

    @(posedge clk); #1;
    result_data_lc  = 16'hFFFF;
    result_valid_lc = 1'b1;
    @(posedge clk); #1;
    result_valid_lc = 1'b0;
    n = 0;
    while (log_lc.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t2_lc_byte_count", log_lc.size(), 5);
    for (int i = 0; i < 4; i++)
      if (i < log_lc.size())
        chk("t2_lc_digit", {24'b0, log_lc[i]}, 32'h66);
    if (log_lc.size() > 4)
      chk("t2_lc_term", {24'b0, log_lc[4]}, 32'h0A);
    repeat (10) @(negedge clk);
    chk("t2_lc_idle", {31'b0, encoder_busy_lc}, 32'h0);

    // 3: overrun during a frame
    base = log_q.size();
    send(16'hABCD, c);
    repeat (20) @(negedge clk);
    send(16'h1234, c);
    chk("t3_overrun_set", {31'b0, overrun}, 32'h1);
    wait_idle("t3");
    chk_frame("t3", base, 5, 40'h41_42_43_44_0A);
    chk("t3_overrun_sticky", {31'b0, overrun}, 32'h1);
    base = log_q.size();
    send(16'h0001, c);
    chk("t3_overrun_cleared", {31'b0, overrun}, 32'h0);
    wait_idle("t3b");
    chk_frame("t3b", base, 5, 40'h30_30_30_31_0A);

    // 4: uart busy for 50 cycles before the first byte
    force_busy = 1'b1;
    base = log_q.size();
    send(16'hA000, c);
    @(negedge clk);
    repeat (50) begin
      @(negedge clk);
      chk("t4_held_data", {24'b0, tx_data}, 32'h41);
      chk("t4_no_start", {31'b0, tx_start}, 32'h0);
    end
    force_busy = 1'b0;
    wait_idle("t4");
    chk_frame("t4", base, 5, 40'h41_30_30_30_0A);

    // 5: reset after two bytes
    base = log_q.size();
    send(16'h5678, c);
    n = 0;
    while (log_q.size() < base + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t5_two_bytes_out", log_q.size() - base, 2);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t5_reset_immediate", {21'b0, tx_data, tx_start, encoder_busy, overrun}, 32'h0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("t5_no_bytes_after_reset", log_q.size() - base, 2);
    base = log_q.size();
    send(16'h0009, c);
    wait_idle("t5");
    chk_frame("t5", base, 5, 40'h30_30_30_39_0A);

    // 6: result on the cycle after encoder_busy falls
    base = log_q.size();
    send(16'h1111, c);
    n = 0;
    @(negedge clk);
    while (encoder_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t6_first_frame_ends", {31'b0, n < 500}, 32'h1);
    result_data  = 16'h2222;
    result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
    chk("t6_accepted", {31'b0, encoder_busy}, 32'h1);
    chk("t6_no_overrun", {31'b0, overrun}, 32'h0);
    wait_idle("t6");
    chk_frame("t6a", base, 10, 40'h31_31_31_31_0A);
    chk_frame("t6b", base + 5, 5, 40'h32_32_32_32_0A);

    // Randomized traffic with random uart byte times
    busy_rand = 1'b1;
    repeat (3000) begin
      @(posedge clk); #1;
      result_valid = ($urandom_range(7, 0) == 0);
      result_data  = 16'($urandom);
    end
    @(posedge clk); #1;
    result_valid = 1'b0;
    wait_idle("random");
    chk("random_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
